isdu_ctrl: RTL

- Instruction-sequence decode unit: the Moore FSM that drives every load, gate and mux select of the LC-3 datapath.
- Consumes IR opcode/flag bits and BEN from the datapath.
- Produces LD_MAR/LD_MDR/LD_IR and related strobes for the MAR/MDR/IR register stage.
- Sequences memory reads and writes with a programmable wait-state counter.

---
 rtl/isdu_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/isdu_ctrl.sv
// rtl/isdu_ctrl.sv - LC-3 instruction-sequence decode FSM with wait-stated memory access
// Build option: define ISDU_PAUSE_EN to enable the PAUSE opcode (1101) and the LD_LED strobe.
module isdu_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S1, S5, S9, S0, S22, S12, S4, S21, S20,
    S6, S7, S25, S27, S23, S16, PAUSE_IR1, PAUSE_IR2
  } state_t;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mem_oe, mem_we;
  } ctl_t;

  // Counter value on the final cycle of a memory access
  localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

  state_t     state, nstate;
  logic [3:0] cnt, ncnt;
  logic       led_pulse;
  ctl_t       ctl;

  // Control word for the state being entered; outputs are flopped so they
  // line up with the state register and never see Opcode combinationally.
  function automatic ctl_t ctl_for(input state_t s, input logic [3:0] c,
                                   input logic ir5, input logic led);
    ctl_t o;
    o = '0;
    case (s)
      S18: begin o.gate_pc = 1'b1; o.ld_mar = 1'b1; o.ld_pc = 1'b1; end
      S33, S25: begin o.mem_oe = 1'b1; o.ld_mdr = (c == LAST); end
      S35: begin o.gate_mdr = 1'b1; o.ld_ir = 1'b1; end
      S32: o.ld_ben = 1'b1;
      S1, S5: begin
        o.sr1mux = 1'b1; o.sr2mux = ir5; o.aluk = (s == S5) ? 2'b01 : 2'b00;
        o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
      end
      S9: begin
        o.sr1mux = 1'b1; o.aluk = 2'b10; o.gate_alu = 1'b1;
        o.ld_reg = 1'b1; o.ld_cc = 1'b1;
      end
      S22: begin o.addr2mux = 2'b10; o.pcmux = 2'b10; o.ld_pc = 1'b1; end
      S12, S20: begin
        o.sr1mux = (s == S12); o.addr1mux = 1'b1; o.pcmux = 2'b10; o.ld_pc = 1'b1;
      end
      S4: begin o.gate_pc = 1'b1; o.drmux = 1'b1; o.ld_reg = 1'b1; end
      S21: begin o.addr2mux = 2'b11; o.pcmux = 2'b10; o.ld_pc = 1'b1; end
      S6, S7: begin
        o.sr1mux = 1'b1; o.addr1mux = 1'b1; o.addr2mux = 2'b01;
        o.gate_marmux = 1'b1; o.ld_mar = 1'b1;
      end
      S27: begin o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1; end
      S23: begin o.aluk = 2'b11; o.gate_alu = 1'b1; o.ld_mdr = 1'b1; end
      S16: o.mem_we = 1'b1;
      PAUSE_IR1: o.ld_led = led;
      default: o = '0;
    endcase
    return o;
  endfunction

  // Next-state and wait-counter sequencing
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      HALTED: if (Run) nstate = S18;
      S18:    nstate = S33;
      S33, S25, S16: begin
        if (cnt == LAST) begin
          ncnt   = '0;
          nstate = (state == S33) ? S35 : (state == S25) ? S27 : S18;
        end else begin
          ncnt = cnt + 4'd1;
        end
      end
      S35:    nstate = S32;
      S32: begin
        case (Opcode)
          4'b0001: nstate = S1;
          4'b0101: nstate = S5;
          4'b1001: nstate = S9;
          4'b0000: nstate = S0;
          4'b1100: nstate = S12;
          4'b0100: nstate = S4;
          4'b0110: nstate = S6;
          4'b0111: nstate = S7;
`ifdef ISDU_PAUSE_EN
          4'b1101: nstate = PAUSE_IR1;
`endif
          default: nstate = S18;
        endcase
      end
      S0:        nstate = BEN ? S22 : S18;
      S4:        nstate = IR_11 ? S21 : S20;
      S6:        nstate = S25;
      S7:        nstate = S23;
      S23:       nstate = S16;
      PAUSE_IR1: if (!Continue) nstate = PAUSE_IR2;
      PAUSE_IR2: if (Continue) nstate = S18;
      default:   nstate = S18;
    endcase
  end

  // LD_LED fires only on the cycle the pause is first entered
`ifdef ISDU_PAUSE_EN
  assign led_pulse = (nstate == PAUSE_IR1) && (state != PAUSE_IR1);
`else
  assign led_pulse = 1'b0;
`endif

  // State, counter and registered control word
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= HALTED;
      cnt   <= '0;
      ctl   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      ctl   <= ctl_for(nstate, ncnt, IR_5, led_pulse);
    end
  end

  assign {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} =
         {ctl.ld_mar, ctl.ld_mdr, ctl.ld_ir, ctl.ld_ben, ctl.ld_cc, ctl.ld_reg, ctl.ld_pc, ctl.ld_led};
  assign {GatePC, GateMDR, GateALU, GateMARMUX} =
         {ctl.gate_pc, ctl.gate_mdr, ctl.gate_alu, ctl.gate_marmux};
  assign PCMUX    = ctl.pcmux;
  assign DRMUX    = ctl.drmux;
  assign SR1MUX   = ctl.sr1mux;
  assign SR2MUX   = ctl.sr2mux;
  assign ADDR1MUX = ctl.addr1mux;
  assign ADDR2MUX = ctl.addr2mux;
  assign ALUK     = ctl.aluk;
  assign Mem_OE   = ctl.mem_oe;
  assign Mem_WE   = ctl.mem_we;

endmodule
